ds1302_poll_ctrl: RTL and testbench

DS1302_POLL_CTRL -- requirements
Module: ds1302_poll_ctrl

---
 rtl/ds1302_poll_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ds1302_poll_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds1302_poll_ctrl.sv
// Polls a DS1302 RTC engine for time, validates BCD and publishes the time; forwards time-set requests.
// Latency: time_* and sec_tick/bcd_err update 2 cycles after read_time_ack.
// Backpressure: requests are level-held until acked or abandoned after TIMEOUT_CYCLES cycles.
module ds1302_poll_ctrl #(
    parameter int unsigned POLL_CYCLES    = 5000000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       set_req,
    input  logic [7:0] set_second,
    input  logic [7:0] set_minute,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_date,
    input  logic [7:0] set_month,
    input  logic [7:0] set_week,
    input  logic [7:0] set_year,
    output logic       write_time_req,
    input  logic       write_time_ack,
    output logic [7:0] write_second,
    output logic [7:0] write_minute,
    output logic [7:0] write_hour,
    output logic [7:0] write_date,
    output logic [7:0] write_month,
    output logic [7:0] write_week,
    output logic [7:0] write_year,
    output logic       read_time_req,
    input  logic       read_time_ack,
    input  logic [7:0] read_second,
    input  logic [7:0] read_minute,
    input  logic [7:0] read_hour,
    input  logic [7:0] read_date,
    input  logic [7:0] read_month,
    input  logic [7:0] read_week,
    input  logic [7:0] read_year,
    output logic [7:0] time_second,
    output logic [7:0] time_minute,
    output logic [7:0] time_hour,
    output logic [7:0] time_date,
    output logic [7:0] time_month,
    output logic [7:0] time_week,
    output logic [7:0] time_year,
    output logic       time_valid,
    output logic       sec_tick,
    output logic       bcd_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WR_REQ = 2'd1;
    localparam logic [1:0] RD_REQ = 2'd2;
    localparam logic [1:0] CHECK  = 2'd3;

    localparam logic [31:0] POLL_RELOAD = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] poll_cnt;
    logic [31:0] tmo_cnt;
    logic        poll_due;
    logic        set_pend;
    logic [7:0]  stg_second, stg_minute, stg_hour, stg_date, stg_month, stg_week, stg_year;
    logic        poll_exp;
    logic        tmo_hit;
    logic        wr_done;
    logic        rd_done;
    logic        stg_ok;
    logic [7:0]  new_second;

    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    assign write_time_req = (state == WR_REQ);
    assign read_time_req  = (state == RD_REQ);
    assign busy           = (state != IDLE);

    assign poll_exp   = (poll_cnt == 32'd0);
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign wr_done    = (state == WR_REQ) && write_time_ack;
    assign rd_done    = (state == RD_REQ) && read_time_ack;
    assign new_second = {1'b0, stg_second[6:0]};

    // Control bits in second[7] and hour[7:6] are not part of the BCD value.
    assign stg_ok = bcd_ok(new_second) && bcd_ok(stg_minute) &&
                    bcd_ok({2'b00, stg_hour[5:0]}) && bcd_ok(stg_date) &&
                    bcd_ok(stg_month) && bcd_ok(stg_year) &&
                    (stg_week >= 8'd1) && (stg_week <= 8'd7);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (set_pend)      state_nxt = WR_REQ;
                else if (poll_due) state_nxt = RD_REQ;
            end
            WR_REQ: begin
                if (write_time_ack) state_nxt = RD_REQ;
                else if (tmo_hit)   state_nxt = IDLE;
            end
            RD_REQ: begin
                if (read_time_ack) state_nxt = CHECK;
                else if (tmo_hit)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            poll_cnt    <= POLL_RELOAD;
            poll_due    <= 1'b0;
            set_pend    <= 1'b0;
            tmo_cnt     <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            poll_cnt    <= poll_exp ? POLL_RELOAD : poll_cnt - 32'd1;
            // An expiry coinciding with RD_REQ entry is kept so no poll is lost.
            if (poll_exp)
                poll_due <= 1'b1;
            else if (state_nxt == RD_REQ && state != RD_REQ)
                poll_due <= 1'b0;
            if (set_req && state != WR_REQ)
                set_pend <= 1'b1;
            else if (wr_done)
                set_pend <= 1'b0;
            if (state_nxt == state && (state == WR_REQ || state == RD_REQ))
                tmo_cnt <= tmo_cnt + 32'd1;
            else
                tmo_cnt <= 32'd0;
            timeout_err <= tmo_hit && ((state == WR_REQ && !write_time_ack) ||
                                       (state == RD_REQ && !read_time_ack));
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            write_second <= 8'h00;
            write_minute <= 8'h00;
            write_hour   <= 8'h00;
            write_date   <= 8'h00;
            write_month  <= 8'h00;
            write_week   <= 8'h00;
            write_year   <= 8'h00;
        end else if (set_req && state != WR_REQ) begin
            write_second <= set_second;
            write_minute <= set_minute;
            write_hour   <= set_hour;
            write_date   <= set_date;
            write_month  <= set_month;
            write_week   <= set_week;
            write_year   <= set_year;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            stg_second <= 8'h00;
            stg_minute <= 8'h00;
            stg_hour   <= 8'h00;
            stg_date   <= 8'h00;
            stg_month  <= 8'h00;
            stg_week   <= 8'h00;
            stg_year   <= 8'h00;
        end else if (rd_done) begin
            stg_second <= read_second;
            stg_minute <= read_minute;
            stg_hour   <= read_hour;
            stg_date   <= read_date;
            stg_month  <= read_month;
            stg_week   <= read_week;
            stg_year   <= read_year;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            time_second <= 8'h00;
            time_minute <= 8'h00;
            time_hour   <= 8'h00;
            time_date   <= 8'h00;
            time_month  <= 8'h00;
            time_week   <= 8'h00;
            time_year   <= 8'h00;
            time_valid  <= 1'b0;
            sec_tick    <= 1'b0;
            bcd_err     <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            bcd_err  <= 1'b0;
            if (state == CHECK) begin
                if (stg_ok) begin
                    time_second <= new_second;
                    time_minute <= stg_minute;
                    time_hour   <= {2'b00, stg_hour[5:0]};
                    time_date   <= stg_date;
                    time_month  <= stg_month;
                    time_week   <= stg_week;
                    time_year   <= stg_year;
                    time_valid  <= 1'b1;
                    sec_tick    <= (new_second != time_second) || !time_valid;
                end else begin
                    bcd_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ds1302_poll_ctrl.sv
// Scoreboard bench: stimulus queues expected events, a negedge monitor pops and compares them.
module tb_ds1302_poll_ctrl;

    localparam int RD_LAT  = 5;
    localparam int WR_LAT  = 3;
    localparam int EV_RD   = 0;
    localparam int EV_WR   = 1;
    localparam int EV_TICK = 2;
    localparam int EV_BCD  = 3;
    localparam int EV_TMO  = 4;

    typedef struct {
        int          kind;
        logic [63:0] dat;
        int          gap;
    } ev_t;

    logic       sysclk = 1'b0;
    logic       rst = 1'b1;
    logic       set_req = 1'b0;
    logic [7:0] set_second = 8'h00, set_minute = 8'h00, set_hour = 8'h00, set_date = 8'h00;
    logic [7:0] set_month = 8'h00, set_week = 8'h00, set_year = 8'h00;
    logic       write_time_req;
    logic       write_time_ack = 1'b0;
    logic [7:0] write_second, write_minute, write_hour, write_date, write_month, write_week, write_year;
    logic       read_time_req;
    logic       read_time_ack = 1'b0;
    logic [7:0] read_second = 8'h00, read_minute = 8'h00, read_hour = 8'h00, read_date = 8'h00;
    logic [7:0] read_month = 8'h00, read_week = 8'h00, read_year = 8'h00;
    logic [7:0] time_second, time_minute, time_hour, time_date, time_month, time_week, time_year;
    logic       time_valid, sec_tick, bcd_err, timeout_err, busy;

    logic [55:0] time_bus, wr_bus;
    assign time_bus = {time_second, time_minute, time_hour, time_date, time_month, time_week, time_year};
    assign wr_bus   = {write_second, write_minute, write_hour, write_date, write_month, write_week, write_year};

    ev_t         exp_q[$];
    logic [55:0] rd_q[$];
    logic [55:0] rtc_now = 56'd0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_ev_cyc = 0;
    int          rd_ack_cyc = -100;
    bit          wr_ack_en = 1'b1;
    bit          prev_wr = 1'b0;
    bit          prev_rd = 1'b0;

    ds1302_poll_ctrl #(.POLL_CYCLES(10), .TIMEOUT_CYCLES(20)) dut (
        .sysclk(sysclk), .rst(rst), .set_req(set_req),
        .set_second(set_second), .set_minute(set_minute), .set_hour(set_hour), .set_date(set_date),
        .set_month(set_month), .set_week(set_week), .set_year(set_year),
        .write_time_req(write_time_req), .write_time_ack(write_time_ack),
        .write_second(write_second), .write_minute(write_minute), .write_hour(write_hour),
        .write_date(write_date), .write_month(write_month), .write_week(write_week), .write_year(write_year),
        .read_time_req(read_time_req), .read_time_ack(read_time_ack),
        .read_second(read_second), .read_minute(read_minute), .read_hour(read_hour),
        .read_date(read_date), .read_month(read_month), .read_week(read_week), .read_year(read_year),
        .time_second(time_second), .time_minute(time_minute), .time_hour(time_hour),
        .time_date(time_date), .time_month(time_month), .time_week(time_week), .time_year(time_year),
        .time_valid(time_valid), .sec_tick(sec_tick), .bcd_err(bcd_err),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    function automatic logic [55:0] t7(input logic [7:0] s, input logic [7:0] mi, input logic [7:0] h,
                                       input logic [7:0] d, input logic [7:0] mo, input logic [7:0] w,
                                       input logic [7:0] y);
        return {s, mi, h, d, mo, w, y};
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_RD:   return "read_req";
            EV_WR:   return "write_req";
            EV_TICK: return "sec_tick";
            EV_BCD:  return "bcd_err";
            default: return "timeout_err";
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [63:0] dat, input int gap);
        ev_t e;
        e.kind = kind;
        e.dat  = dat;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [63:0] dat);
        ev_t e;
        int  gap;
        gap = cyc - last_ev_cyc;
        last_ev_cyc = cyc;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected %s at cycle %0d: got data %h, required no event", kname(kind), cyc, dat);
            return;
        end
        e = exp_q.pop_front();
        chk("event kind", 64'(kind), 64'(e.kind));
        chk({kname(e.kind), " data"}, dat, e.dat);
        if (e.gap >= 0)
            chk({kname(e.kind), " cycles since previous event"}, 64'(gap), 64'(e.gap));
        if (kind == EV_TICK || kind == EV_BCD)
            chk({kname(kind), " cycles after read ack"}, 64'(cyc - rd_ack_cyc), 64'd2);
    endtask

    always @(negedge sysclk) begin
        if (rst) begin
            prev_wr = 1'b0;
            prev_rd = 1'b0;
        end else begin
            if (timeout_err) take(EV_TMO, 64'd0);
            if (bcd_err) take(EV_BCD, {7'd0, time_valid, time_bus});
            if (sec_tick) take(EV_TICK, {7'd0, time_valid, time_bus});
            if (write_time_req && !prev_wr) take(EV_WR, {8'd0, wr_bus});
            if (read_time_req && !prev_rd) take(EV_RD, 64'd0);
            prev_wr = write_time_req;
            prev_rd = read_time_req;
        end
    end

    // RTC engine model: acks reads RD_LAT cycles and writes WR_LAT cycles after the request rises.
    initial begin
        int          rd_age;
        int          wr_age;
        logic [55:0] rtc;
        rd_age = 0;
        wr_age = 0;
        forever begin
            @(posedge sysclk);
            #1;
            read_time_ack  = 1'b0;
            write_time_ack = 1'b0;
            if (rst) begin
                rd_age = 0;
                wr_age = 0;
            end else begin
                rd_age = read_time_req ? rd_age + 1 : 0;
                wr_age = write_time_req ? wr_age + 1 : 0;
                if (read_time_req && rd_age == RD_LAT + 1) begin
                    rtc = (rd_q.size() > 0) ? rd_q.pop_front() : rtc_now;
                    {read_second, read_minute, read_hour, read_date, read_month, read_week, read_year} = rtc;
                    read_time_ack = 1'b1;
                    rd_ack_cyc    = cyc;
                end
                if (write_time_req && wr_ack_en && wr_age >= WR_LAT + 1) begin
                    write_time_ack = 1'b1;
                    rtc_now        = wr_bus;
                end
            end
        end
    end

    task automatic do_set(input logic [55:0] v);
        {set_second, set_minute, set_hour, set_date, set_month, set_week, set_year} = v;
        set_req = 1'b1;
        @(posedge sysclk);
        #1;
        set_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge sysclk);
            #1;
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d expected events never seen, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        logic [55:0] v1, v3, v5, w1, w2;
        v1 = t7(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
        v3 = t7(8'h00, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99);
        v5 = t7(8'h55, 8'h59, 8'h12, 8'h31, 8'h12, 8'h07, 8'h99);
        w1 = t7(8'h30, 8'h15, 8'h08, 8'h21, 8'h06, 8'h03, 8'h24);
        w2 = t7(8'h12, 8'h34, 8'h11, 8'h05, 8'h09, 8'h02, 8'h25);

        #12;
        chk("reset time_*", {8'd0, time_bus}, 64'd0);
        chk("reset write_*", {8'd0, wr_bus}, 64'd0);
        chk("reset flags", {58'd0, time_valid, sec_tick, bcd_err, timeout_err, busy, 1'b0},
            64'd0);
        chk("reset requests", {62'd0, write_time_req, read_time_req}, 64'd0);

        // Polled reads: tick, same value, new second, bad BCD, masked bits, bad week/month.
        rd_q.push_back(v1);
        rd_q.push_back(v1);
        rd_q.push_back(v3);
        rd_q.push_back(t7(8'h5A, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99));
        rd_q.push_back(t7(8'hD5, 8'h59, 8'h52, 8'h31, 8'h12, 8'h07, 8'h99));
        rd_q.push_back(t7(8'h55, 8'h59, 8'h12, 8'h31, 8'h12, 8'h00, 8'h99));
        rd_q.push_back(t7(8'h55, 8'h59, 8'h12, 8'h31, 8'h1A, 8'h07, 8'h99));
        rd_q.push_back(t7(8'h55, 8'h59, 8'h12, 8'h31, 8'h12, 8'h08, 8'h99));
        push(EV_RD, 64'd0, -1);
        push(EV_TICK, {8'h01, v1}, 7);
        push(EV_RD, 64'd0, 3);
        push(EV_RD, 64'd0, 10);
        push(EV_TICK, {8'h01, v3}, 7);
        push(EV_RD, 64'd0, 3);
        push(EV_BCD, {8'h01, v3}, 7);
        push(EV_RD, 64'd0, 3);
        push(EV_TICK, {8'h01, v5}, 7);
        for (int i = 0; i < 3; i++) begin
            push(EV_RD, 64'd0, 3);
            push(EV_BCD, {8'h01, v5}, 7);
        end
        push(EV_RD, 64'd0, 3);
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        wait_drain("poll reads");

        chk("read req before reset", {63'd0, read_time_req}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async reset read req", {63'd0, read_time_req}, 64'd0);
        chk("async reset time_valid", {63'd0, time_valid}, 64'd0);
        chk("async reset time_* and busy", {7'd0, busy, time_bus}, 64'd0);

        // Set request coinciding with poll expiry; write first, refresh read follows.
        push(EV_WR, {8'd0, w1}, -1);
        push(EV_RD, 64'd0, 4);
        push(EV_TICK, {8'h01, w1}, 7);
        push(EV_RD, 64'd0, 1);
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        repeat (9) @(posedge sysclk);
        #1;
        do_set(w1);
        repeat (2) @(posedge sysclk);
        #1;
        do_set(t7(8'h45, 8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00));
        chk("write_* held during WR_REQ", {8'd0, wr_bus}, {8'd0, w1});
        chk("write req and busy during WR_REQ", {62'd0, write_time_req, busy}, 64'd3);
        wait_drain("write then refresh");
        rst = 1'b1;

        // Unacked write: timeout after 20 cycles, then retried and completed.
        wr_ack_en = 1'b0;
        push(EV_WR, {8'd0, w2}, -1);
        push(EV_TMO, 64'd0, 20);
        push(EV_WR, {8'd0, w2}, 1);
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        @(posedge sysclk);
        #1;
        do_set(w2);
        wait_drain("write timeout");
        wr_ack_en = 1'b1;
        push(EV_RD, 64'd0, 4);
        push(EV_TICK, {8'h01, w2}, 7);
        push(EV_RD, 64'd0, 1);
        wait_drain("retried write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
